freq_meter: RTL and testbench
=============================

FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter GATE_DIV, default 1, gate window = CLK_FREQ/GATE_DIV clock cycles; reported Hz = edge count * GATE_DIV.
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  measurement enable.
REQ-006 sig_in  input  1  asynchronous square-wave input to be measured.
REQ-007 freq  output  32  last completed measurement in Hz.
REQ-008 freq_valid  output  1  one-cycle pulse when freq updates.
REQ-009 no_signal  output  1  high when the last completed window saw zero rising edges.

Function
REQ-010 sig_in SHALL pass a 2-flop synchronizer, then a rising-edge detector; an edge is reported 3 clk cycles after the input transition.
REQ-011 Gate counter SHALL count 0 .. GATE_CYCLES-1 (GATE_CYCLES = CLK_FREQ/GATE_DIV, minimum 1), wrapping to 0 while en=1.
REQ-012 Edge counter SHALL increment once per detected rising edge and saturate at 32'hFFFFFFFF.
REQ-013 Edge on the last gate cycle SHALL be counted in the closing window, not the next.
REQ-014 Cycle after the last gate cycle: freq <= edge count * GATE_DIV, saturated to 32'hFFFFFFFF; freq_valid pulses high for exactly that cycle; edge counter restarts at 0, or 1 if an edge occurs that cycle.
REQ-015 no_signal SHALL update together with freq: 1 if the window count was 0, else 0.
REQ-016 en=0 SHALL hold gate and edge counters at 0 and keep freq_valid at 0; freq and no_signal keep their last values.
REQ-017 en rising SHALL start a fresh full window; partial windows SHALL never be reported.

Reset
REQ-018 rst=1 at any clock edge SHALL clear: synchronizer flops 0, gate and edge counters 0, freq 0, freq_valid 0, no_signal 1, period 0, period_valid 0, period FSM WAIT_EDGE.
REQ-019 rst mid-window SHALL discard the partial count; the first report comes a full window after rst deasserts with en=1.

Configuration
REQ-020 Macro FREQ_METER_PERIOD_EN SHALL compile in outputs period (32, clk cycles between consecutive rising edges) and period_valid (1, one-cycle pulse).
REQ-021 With the macro, FSM WAIT_EDGE -> MEASURE on an edge, counter = 1.
REQ-022 In MEASURE, the counter increments each cycle. On an edge: period <= counter, period_valid pulses, counter = 1.
REQ-023 In MEASURE, when the counter reaches CLK_FREQ: period <= 0, no pulse, and the FSM returns to WAIT_EDGE.
REQ-024 en=0 SHALL force WAIT_EDGE.
REQ-025 Without the macro, period ports and FSM SHALL be absent; the freq path SHALL be unchanged.

Structure
REQ-026 Package freq_meter_pkg SHALL hold the period FSM state encoding (WAIT_EDGE, MEASURE), the saturation constant 32'hFFFFFFFF and the synchronizer depth (2).
REQ-027 Sub-module edge_sync (synchronizer plus rising-edge pulse) SHALL be the single child instance.

Verification (CLK_FREQ=1000, GATE_DIV=1 unless stated)
REQ-028 sig_in toggles every 50 cycles, en=1 -> freq=10, no_signal=0, one freq_valid pulse per 1000 cycles; with macro, period=100 with a period_valid pulse on each edge after the first.
REQ-029 sig_in held 0 -> freq=0, no_signal=1 each window; with macro, period=0 after 1000 cycles, no period_valid.
REQ-030 rst asserted at cycle 500 of a window while toggling -> all outputs at reset values; first freq_valid exactly 1000 cycles after rst deasserts (window start), reporting a full-window count.
REQ-031 Synchronized edge landing on gate cycle 999 -> counted in the closing window (freq = N+1); next window starts at 0.
REQ-032 en dropped mid-window for 200 cycles -> no freq_valid, freq held; after en returns, the next report comes 1000 cycles later.
REQ-033 GATE_DIV=1000, CLK_FREQ=1000 (1-cycle gate), sig_in toggling every cycle -> freq alternates 0/1000, freq_valid every cycle.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared constants for the frequency meter: synchronizer depth, saturation value,
// period FSM state encoding and a saturating multiply helper.
package freq_meter_pkg;

  localparam int          SYNC_DEPTH = 2;
  localparam logic [31:0] SAT32      = 32'hFFFF_FFFF;

  localparam logic [0:0] WAIT_EDGE = 1'b0;
  localparam logic [0:0] MEASURE   = 1'b1;

  // Period FSM state and running cycle count, kept together so the state is observable.
  typedef struct packed {
    logic [0:0]  state;
    logic [31:0] count;
  } period_fsm_t;

  function automatic logic [31:0] sat_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    return (prod[63:32] != 32'd0) ? SAT32 : prod[31:0];
  endfunction

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Brings the asynchronous input into the clk domain and emits a one-cycle pulse
// for every synchronized rising edge.
module edge_sync
  import freq_meter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], sig_i};
      prev_q <= sync_q[SYNC_DEPTH-1];
    end
  end

  assign rise_o = sync_q[SYNC_DEPTH-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated-window frequency meter. Define FREQ_METER_PERIOD_EN to add the
// edge-to-edge period measurement outputs (period, period_valid).
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned GATE_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        sig_in,
  output logic [31:0] freq,
  output logic        freq_valid,
  output logic        no_signal
`ifdef FREQ_METER_PERIOD_EN
  ,
  output logic [31:0] period,
  output logic        period_valid
`endif
);

  localparam int unsigned GATE_RAW    = CLK_FREQ / GATE_DIV;
  localparam int unsigned GATE_CYCLES = (GATE_RAW == 0) ? 1 : GATE_RAW;
  localparam logic [31:0] GATE_LAST   = 32'(GATE_CYCLES - 1);

  logic rise;

  edge_sync u_edge_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .sig_i  (sig_in),
    .rise_o (rise)
  );

  logic [31:0] gate_q, gate_d;
  logic [31:0] edge_cnt_q, edge_cnt_d;
  logic [31:0] freq_q, freq_d;
  logic        freq_valid_q, freq_valid_d;
  logic        no_signal_q, no_signal_d;
  logic [31:0] win_count;

  // win_count already includes an edge arriving on the closing gate cycle.
  always_comb begin
    win_count    = (rise && edge_cnt_q != SAT32) ? edge_cnt_q + 32'd1 : edge_cnt_q;
    gate_d       = gate_q;
    edge_cnt_d   = edge_cnt_q;
    freq_d       = freq_q;
    freq_valid_d = 1'b0;
    no_signal_d  = no_signal_q;
    if (!en) begin
      gate_d     = 32'd0;
      edge_cnt_d = 32'd0;
    end else if (gate_q == GATE_LAST) begin
      gate_d       = 32'd0;
      edge_cnt_d   = 32'd0;
      freq_d       = sat_mul(win_count, 32'(GATE_DIV));
      freq_valid_d = 1'b1;
      no_signal_d  = (win_count == 32'd0);
    end else begin
      gate_d     = gate_q + 32'd1;
      edge_cnt_d = win_count;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_q       <= 32'd0;
      edge_cnt_q   <= 32'd0;
      freq_q       <= 32'd0;
      freq_valid_q <= 1'b0;
      no_signal_q  <= 1'b1;
    end else begin
      gate_q       <= gate_d;
      edge_cnt_q   <= edge_cnt_d;
      freq_q       <= freq_d;
      freq_valid_q <= freq_valid_d;
      no_signal_q  <= no_signal_d;
    end
  end

  assign freq       = freq_q;
  assign freq_valid = freq_valid_q;
  assign no_signal  = no_signal_q;

`ifdef FREQ_METER_PERIOD_EN
  localparam logic [31:0] PERIOD_MAX = 32'(CLK_FREQ);

  period_fsm_t fsm_q, fsm_d;
  logic [31:0] period_q, period_d;
  logic        period_valid_q, period_valid_d;

  // A run of CLK_FREQ cycles without an edge abandons the measurement.
  always_comb begin
    fsm_d          = fsm_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    if (!en) begin
      fsm_d.state = WAIT_EDGE;
      fsm_d.count = 32'd0;
    end else if (fsm_q.state == WAIT_EDGE) begin
      if (rise) begin
        fsm_d.state = MEASURE;
        fsm_d.count = 32'd1;
      end
    end else begin
      if (rise) begin
        period_d       = fsm_q.count;
        period_valid_d = 1'b1;
        fsm_d.count    = 32'd1;
      end else if (fsm_q.count == PERIOD_MAX) begin
        period_d    = 32'd0;
        fsm_d.state = WAIT_EDGE;
        fsm_d.count = 32'd0;
      end else begin
        fsm_d.count = fsm_q.count + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q.state    <= WAIT_EDGE;
      fsm_q.count    <= 32'd0;
      period_q       <= 32'd0;
      period_valid_q <= 1'b0;
    end else begin
      fsm_q          <= fsm_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: a 1000-cycle-gate instance and a 1-cycle-gate instance
// (GATE_DIV=1000) share stimulus and are compared against a window-level model.
module tb_freq_meter;

  localparam int unsigned CF     = 1000;
  localparam longint      SAT    = 64'h0000_0000_FFFF_FFFF;
  localparam int unsigned GC [2] = '{1000, 1};
  localparam int unsigned GD [2] = '{1, 1000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sig_in = 1'b0;
  logic [31:0] freq, freq2;
  logic        freq_valid, freq_valid2, no_signal, no_signal2;
`ifdef FREQ_METER_PERIOD_EN
  logic [31:0] period, period2;
  logic        period_valid, period_valid2;
`endif

  freq_meter #(.CLK_FREQ(1000), .GATE_DIV(1)) dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq(freq), .freq_valid(freq_valid), .no_signal(no_signal)
`ifdef FREQ_METER_PERIOD_EN
    , .period(period), .period_valid(period_valid)
`endif
  );

  freq_meter #(.CLK_FREQ(1000), .GATE_DIV(1000)) dut_g (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq(freq2), .freq_valid(freq_valid2), .no_signal(no_signal2)
`ifdef FREQ_METER_PERIOD_EN
    , .period(period2), .period_valid(period_valid2)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          cyc = 0;
  bit          model_ok = 0;
  int          samp[$];
  int unsigned pos[2];
  longint      cnt[2];
  logic [31:0] ef[2];
  logic        ev[2], ens[2];
  logic [32:0] exp_q[$];
  int          armed = 0, last_edge = 0;
  logic [31:0] exp_per = 0;
  logic        exp_pv = 0;

  task automatic model_step();
    bit e;
    longint p;
    if (rst) begin
      samp = '{0, 0, 0};
      model_ok = 1;
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
        pos[i] = 0; cnt[i] = 0; ef[i] = 0; ev[i] = 0; ens[i] = 1;
      end
      armed = 0; exp_per = 0; exp_pv = 0;
      return;
    end
    if (!model_ok) return;
    // a rise seen on the input two and three samples back is acted on now
    e = (samp[1] == 1 && samp[0] == 0);
    samp.push_back(int'(sig_in));
    void'(samp.pop_front());
    for (int i = 0; i < 2; i++) begin
      ev[i] = 0;
      if (!en) begin
        pos[i] = 0; cnt[i] = 0;
      end else begin
        cnt[i] += longint'(e);
        pos[i]++;
        if (pos[i] == GC[i]) begin
          p      = cnt[i] * longint'(GD[i]);
          ef[i]  = (p > SAT) ? 32'hFFFF_FFFF : p[31:0];
          ens[i] = (cnt[i] == 0);
          ev[i]  = 1;
          if (i == 0) exp_q.push_back({ens[i], ef[i]});
          pos[i] = 0; cnt[i] = 0;
        end
      end
    end
    exp_pv = 0;
    if (!en) armed = 0;
    else if (e) begin
      if (armed != 0) begin exp_per = 32'(cyc - last_edge); exp_pv = 1; end
      armed = 1; last_edge = cyc;
    end else if (armed != 0 && cyc - last_edge == int'(CF)) begin
      exp_per = 0; armed = 0;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int lat = -1, mark = 0, cnt_v2 = 0;
  bit lat_armed = 0;
  logic [32:0] sb;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      if (model_ok) begin
        check_eq("valid", 32'(freq_valid), 32'(ev[0]));
        check_eq("freq", freq, ef[0]);
        check_eq("no_signal", 32'(no_signal), 32'(ens[0]));
        check_eq("valid_g", 32'(freq_valid2), 32'(ev[1]));
        check_eq("freq_g", freq2, ef[1]);
        check_eq("no_signal_g", 32'(no_signal2), 32'(ens[1]));
`ifdef FREQ_METER_PERIOD_EN
        check_eq("period", period, exp_per);
        check_eq("period_valid", 32'(period_valid), 32'(exp_pv));
        check_eq("period_g", period2, exp_per);
`endif
        if (freq_valid) begin
          if (exp_q.size() == 0) check_eq("sb_spurious", 32'(freq_valid), 32'd0);
          else begin
            sb = exp_q.pop_front();
            check_eq("sb_freq", freq, sb[31:0]);
            check_eq("sb_nosig", 32'(no_signal), 32'(sb[32]));
          end
        end
        if (freq_valid2) cnt_v2++;
        if (lat_armed && freq_valid) begin
          lat = cyc - mark;
          lat_armed = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int ncyc, input int half);
    int k = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (half > 0) begin
        k++;
        if (k >= half) begin
          sig_in = ~sig_in;
          k = 0;
        end
      end
    end
  endtask

  task automatic arm_latency();
    mark = cyc;
    lat = -1;
    lat_armed = 1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_freq"}, freq, 32'd0);
    check_eq({tag, "_valid"}, 32'(freq_valid), 32'd0);
    check_eq({tag, "_nosig"}, 32'(no_signal), 32'd1);
    check_eq({tag, "_freq_g"}, freq2, 32'd0);
`ifdef FREQ_METER_PERIOD_EN
    check_eq({tag, "_period"}, period, 32'd0);
    check_eq({tag, "_pvalid"}, 32'(period_valid), 32'd0);
`endif
  endtask

  initial begin
    drive(5, 0);
    check_reset_values("reset");

    // steady 100-cycle period input
    rst = 0; en = 1; arm_latency();
    drive(2100, 50);
    check_eq("first_report_lat", 32'(lat), 32'd1000);
    check_eq("freq_10", freq, 32'd10);
    check_eq("nosig_0", 32'(no_signal), 32'd0);
`ifdef FREQ_METER_PERIOD_EN
    check_eq("period_100", period, 32'd100);
`endif

    // enable dropped mid-window for 200 cycles
    drive(300, 50);
    en = 0;
    drive(200, 50);
    en = 1; arm_latency();
    drive(1500, 50);
    check_eq("en_return_lat", 32'(lat), 32'd1000);
    check_eq("en_return_freq", freq, 32'd10);

    // reset 500 cycles into a window
    rst = 1;
    drive(3, 50);
    check_reset_values("midrst");
    rst = 0; arm_latency();
    drive(1100, 50);
    check_eq("rst_lat", 32'(lat), 32'd1000);
    check_eq("rst_freq", freq, 32'd10);

    // input stuck low
    sig_in = 0;
    drive(2100, 0);
    check_eq("stuck_freq", freq, 32'd0);
    check_eq("stuck_nosig", 32'(no_signal), 32'd1);
`ifdef FREQ_METER_PERIOD_EN
    check_eq("stuck_period", period, 32'd0);
`endif

    // single edge landing on the last gate cycle
    rst = 1;
    drive(2, 0);
    rst = 0;
    drive(997, 0);
    sig_in = 1;
    drive(10, 0);
    check_eq("last_gate_freq", freq, 32'd1);
    check_eq("last_gate_nosig", 32'(no_signal), 32'd0);
    drive(1000, 0);
    check_eq("next_window_freq", freq, 32'd0);

    // randomized rates and enable gaps
    for (int r = 0; r < 30; r++) begin
      en = ($urandom_range(0, 4) != 0);
      drive($urandom_range(50, 400), $urandom_range(0, 60));
    end

    // 1-cycle gate, input toggling every cycle
    en = 1; cnt_v2 = 0;
    drive(40, 1);
    check_eq("gate1_pulses", 32'(cnt_v2), 32'd40);

    drive(5, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
